// File: rtl/soml_frame_buffer_if.sv
// soml_frame_buffer_if: stream-in and frame-out bus of the SOML ping-pong input buffer.
//   start                         arm loading of the next frame
//   h_valid/h_ready, h_r/h_i      H element stream, row-major (row=rx, col=tx)
//   y_valid/y_ready, y_r/y_i      Y element stream, slot-major
//   frm_valid/frm_ready           frame handshake towards the Hq/trace engine
//   H_r/H_i, Y_r/Y_i              flattened H and Y of the read bank
//   frm_id, busy, err             frame id, write-FSM busy, sticky protocol error
// master drives the streams and consumes frames; slave is the buffer.
interface soml_frame_buffer_if #(
  parameter int N     = 32,
  parameter int NR    = 4,
  parameter int NT    = 4,
  parameter int T     = 2,
  parameter int FID_W = 4
);
  logic                 start;
  logic                 h_valid, h_ready;
  logic [N-1:0]         h_r, h_i;
  logic                 y_valid, y_ready;
  logic [N-1:0]         y_r, y_i;
  logic                 frm_valid, frm_ready;
  logic [N*NR*NT-1:0]   H_r, H_i;
  logic [N*NR*T-1:0]    Y_r, Y_i;
  logic [FID_W-1:0]     frm_id;
  logic                 busy, err;
  modport master (
    output start, h_valid, h_r, h_i, y_valid, y_r, y_i, frm_ready,
    input  h_ready, y_ready, frm_valid, H_r, H_i, Y_r, Y_i, frm_id, busy, err
  );
  modport slave (
    input  start, h_valid, h_r, h_i, y_valid, y_r, y_i, frm_ready,
    output h_ready, y_ready, frm_valid, H_r, H_i, Y_r, Y_i, frm_id, busy, err
  );
endinterface

// File: rtl/soml_frame_buffer.sv
// soml_frame_buffer: ping-pong H/Y input buffer for the SOML decoder.
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   soml_frame_buffer_if.slave (streams in, flattened frame out)
// Define SOML_Y_CONJ_EN to store conj(Y): Y imag negated, -2^(N-1) saturating to 2^(N-1)-1.
module soml_frame_buffer #(
  parameter int N     = 32,
  parameter int NR    = 4,
  parameter int NT    = 4,
  parameter int T     = 2,
  parameter int FID_W = 4
) (
  input logic clk,
  input logic rst,
  soml_frame_buffer_if.slave bus
);
  localparam int HN = NR * NT;
  localparam int YN = NR * T;
  localparam int HC = $clog2(HN + 1);
  localparam int YC = $clog2(YN + 1);
  localparam int HA = $clog2(HN);
  localparam int YA = $clog2(YN);
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_LOAD} w_state_t;
  w_state_t state, nxt;
  logic [HC-1:0] h_cnt;
  logic [YC-1:0] y_cnt;
  logic wr_sel, rd_sel, rd_sel_n;
  logic [1:0] full, full_n;
  logic h_acc, y_acc, done, take;
  logic [N-1:0] yi_w;
  logic [N-1:0] hr_m [2][HN];
  logic [N-1:0] hi_m [2][HN];
  logic [N-1:0] yr_m [2][YN];
  logic [N-1:0] yi_m [2][YN];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= W_IDLE;
    else state <= nxt;
  always_comb
    nxt = state == W_IDLE ? (bus.start ? (full[wr_sel] ? W_WAIT : W_LOAD) : W_IDLE)
        : state == W_WAIT ? (full[wr_sel] ? W_WAIT : W_LOAD)
        : done ? W_IDLE : W_LOAD;
  always_comb begin
    bus.h_ready = state == W_LOAD && h_cnt < HC'(HN);
    bus.y_ready = state == W_LOAD && y_cnt < YC'(YN);
    bus.busy = state != W_IDLE;
  end
  assign h_acc = bus.h_valid && bus.h_ready;
  assign y_acc = bus.y_valid && bus.y_ready;
  // Completion looks ahead by the beats accepted this cycle so frm_valid rises one cycle after the last beat.
  assign done = state == W_LOAD && (h_cnt + HC'(h_acc)) == HC'(HN) && (y_cnt + YC'(y_acc)) == YC'(YN);
  assign take = bus.frm_valid && bus.frm_ready;
  assign rd_sel_n = rd_sel ^ take;
  // Free before fill, so a bank released and refilled in the same cycle ends up full.
  always_comb begin
    full_n = full;
    if (take) full_n[rd_sel] = 1'b0;
    if (done) full_n[wr_sel] = 1'b1;
  end
`ifdef SOML_Y_CONJ_EN
  assign yi_w = bus.y_i == {1'b1, {(N-1){1'b0}}} ? {1'b0, {(N-1){1'b1}}} : -bus.y_i;
`else
  assign yi_w = bus.y_i;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_cnt <= '0;
      y_cnt <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      full <= '0;
      bus.frm_valid <= 1'b0;
      bus.frm_id <= '0;
      bus.err <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < HN; e++) begin
          hr_m[b][e] <= '0;
          hi_m[b][e] <= '0;
        end
        for (int e = 0; e < YN; e++) begin
          yr_m[b][e] <= '0;
          yi_m[b][e] <= '0;
        end
      end
    end else begin
      if (state != W_LOAD && nxt == W_LOAD) begin
        h_cnt <= '0;
        y_cnt <= '0;
      end else begin
        if (h_acc) h_cnt <= h_cnt + HC'(1);
        if (y_acc) y_cnt <= y_cnt + YC'(1);
      end
      if (h_acc) begin
        hr_m[wr_sel][h_cnt[HA-1:0]] <= bus.h_r;
        hi_m[wr_sel][h_cnt[HA-1:0]] <= bus.h_i;
      end
      if (y_acc) begin
        yr_m[wr_sel][y_cnt[YA-1:0]] <= bus.y_r;
        yi_m[wr_sel][y_cnt[YA-1:0]] <= yi_w;
      end
      if (done) wr_sel <= ~wr_sel;
      full <= full_n;
      rd_sel <= rd_sel_n;
      bus.frm_valid <= full_n[rd_sel_n];
      if (take) bus.frm_id <= bus.frm_id + FID_W'(1);
      if (bus.start && state != W_IDLE) bus.err <= 1'b1;
    end
  // Arrival order equals the flattened element index for both H and Y.
  for (genvar g = 0; g < HN; g++) begin : g_h
    assign bus.H_r[g*N +: N] = hr_m[rd_sel][g];
    assign bus.H_i[g*N +: N] = hi_m[rd_sel][g];
  end
  for (genvar g = 0; g < YN; g++) begin : g_y
    assign bus.Y_r[g*N +: N] = yr_m[rd_sel][g];
    assign bus.Y_i[g*N +: N] = yi_m[rd_sel][g];
  end
endmodule

// File: tb/tb_soml_frame_buffer.sv
// tb_soml_frame_buffer: directed self-checking bench for soml_frame_buffer.
module tb_soml_frame_buffer;
  localparam int N = 32, NR = 4, NT = 4, T = 2, FID_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int hk, yk, cyc, k;
  logic [N*NR*NT-1:0] eh;
  logic [N*NR*T-1:0] eyr, eyi;
  soml_frame_buffer_if #(.N(N), .NR(NR), .NT(NT), .T(T), .FID_W(FID_W)) bus();
  soml_frame_buffer #(.N(N), .NR(NR), .NT(NT), .T(T), .FID_W(FID_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [31:0] yexp(input logic [31:0] v);
`ifdef SOML_Y_CONJ_EN
    return v == 32'h8000_0000 ? 32'h7fff_ffff : -v;
`else
    return v;
`endif
  endfunction
  task automatic send_h(input logic [31:0] r, input logic [31:0] i);
    int n = 0;
    bus.h_valid = 1'b1;
    bus.h_r = r;
    bus.h_i = i;
    while (!bus.h_ready && n < 8) begin
      tick;
      n++;
    end
    check("h_ready", bus.h_ready, 1);
    tick;
    bus.h_valid = 1'b0;
  endtask
  task automatic send_y(input logic [31:0] r, input logic [31:0] i);
    int n = 0;
    bus.y_valid = 1'b1;
    bus.y_r = r;
    bus.y_i = i;
    while (!bus.y_ready && n < 8) begin
      tick;
      n++;
    end
    check("y_ready", bus.y_ready, 1);
    tick;
    bus.y_valid = 1'b0;
  endtask
  task automatic send_hs(input int hb, input int from, input int to);
    for (int e = from; e < to; e++) send_h(hb + e, e);
  endtask
  task automatic send_ys(input int yb, input int from, input int to, input logic fix, input logic [31:0] yv);
    for (int e = from; e < to; e++) send_y(yb + e, fix ? yv : e);
  endtask
  task automatic start_pulse;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 0; bus.h_valid = 0; bus.h_r = 0; bus.h_i = 0;
    bus.y_valid = 0; bus.y_r = 0; bus.y_i = 0; bus.frm_ready = 0;
    @(negedge clk);
    tick;
    check("rst_h_ready", bus.h_ready, 0);
    check("rst_y_ready", bus.y_ready, 0);
    check("rst_frm_valid", bus.frm_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_frm_id", bus.frm_id, 0);
    check("rst_H_zero", bus.H_r == '0 && bus.Y_i == '0, 1);
    rst = 1'b0;
    tick;
    // 1: basic frame, consumed immediately
    bus.frm_ready = 1'b1;
    start_pulse;
    check("t1_busy", bus.busy, 1);
    send_hs(0, 0, 16);
    send_ys(32, 0, 7, 1'b1, 5);
    bus.y_valid = 1'b1; bus.y_r = 39; bus.y_i = 5;
    check("t1_pre_valid", bus.frm_valid, 0);
    check("t1_last_ready", bus.y_ready, 1);
    tick;
    bus.y_valid = 1'b0;
    check("t1_frm_valid", bus.frm_valid, 1);
    check("t1_frm_id0", bus.frm_id, 0);
    check("t1_busy_done", bus.busy, 0);
    check("t1_H_r_2_3", bus.H_r[(2*4+3)*N +: N], 11);
    check("t1_H_i_0_1", bus.H_i[1*N +: N], 1);
    check("t1_Y_r_1_3", bus.Y_r[7*N +: N], 39);
`ifdef SOML_Y_CONJ_EN
    check("t2_Y_i_5", bus.Y_i[0 +: N], 32'hffff_fffb);
`else
    check("t2_Y_i_5", bus.Y_i[0 +: N], 5);
`endif
    tick;
    bus.frm_ready = 1'b0;
    check("t1_consumed", bus.frm_valid, 0);
    check("t1_frm_id1", bus.frm_id, 1);
    // 3: two frames back-to-back with no consumer, then a third waits for a free bank
    start_pulse;
    send_hs(1000, 0, 16);
    send_y(1032, 32'h8000_0000);
    send_ys(1032, 1, 8, 1'b0, 0);
    check("t3_A_valid", bus.frm_valid, 1);
`ifdef SOML_Y_CONJ_EN
    check("t2_Y_i_min", bus.Y_i[0 +: N], 32'h7fff_ffff);
    check("t2_Y_i_3", bus.Y_i[3*N +: N], 32'hffff_fffd);
`else
    check("t2_Y_i_min", bus.Y_i[0 +: N], 32'h8000_0000);
    check("t2_Y_i_3", bus.Y_i[3*N +: N], 3);
`endif
    start_pulse;
    send_hs(2000, 0, 16);
    send_ys(2032, 0, 8, 1'b0, 0);
    check("t3_B_done_busy", bus.busy, 0);
    check("t3_A_held", bus.H_r[0 +: N], 1000);
    check("t3_A_valid_held", bus.frm_valid, 1);
    start_pulse;
    check("t3_wait_busy", bus.busy, 1);
    check("t3_wait_h_ready", bus.h_ready, 0);
    tick;
    tick;
    check("t3_still_wait", bus.h_ready, 0);
    bus.frm_ready = 1'b1;
    tick;
    bus.frm_ready = 1'b0;
    check("t3_B_valid", bus.frm_valid, 1);
    check("t3_B_data", bus.H_r[0 +: N], 2000);
    check("t3_frm_id2", bus.frm_id, 2);
    k = 0;
    while (!bus.h_ready && k < 5) begin
      tick;
      k++;
    end
    check("t3_C_loading", bus.h_ready, 1);
    // 4: interleaved H/Y with random gaps; excess beats must be refused
    hk = 0; yk = 0; cyc = 0;
    while ((hk < 16 || yk < 8) && cyc < 300) begin
      bus.h_valid = ($urandom_range(0, 2) != 0);
      bus.h_r = 3000 + hk; bus.h_i = hk;
      bus.y_valid = ($urandom_range(0, 2) != 0);
      bus.y_r = 4000 + yk; bus.y_i = yk + 7;
      check("t4_h_ready", bus.h_ready, hk < 16);
      check("t4_y_ready", bus.y_ready, yk < 8);
      if (bus.h_valid && hk < 16) hk++;
      if (bus.y_valid && yk < 8) yk++;
      tick;
      cyc++;
    end
    bus.h_valid = 1'b0; bus.y_valid = 1'b0;
    check("t4_bounded", cyc < 300, 1);
    check("t4_busy", bus.busy, 0);
    check("t4_B_still", bus.H_r[0 +: N], 2000);
    for (int e = 0; e < 16; e++) eh[e*N +: N] = 3000 + e;
    for (int e = 0; e < 8; e++) begin
      eyr[e*N +: N] = 4000 + e;
      eyi[e*N +: N] = yexp(e + 7);
    end
    bus.frm_ready = 1'b1;
    tick;
    bus.frm_ready = 1'b0;
    check("t4_C_valid", bus.frm_valid, 1);
    check("t4_frm_id3", bus.frm_id, 3);
    check("t4_H_r", bus.H_r == eh, 1);
    check("t4_Y_r", bus.Y_r == eyr, 1);
    check("t4_Y_i", bus.Y_i == eyi, 1);
    // 5: start during load flags err without disturbing the load
    start_pulse;
    send_hs(5000, 0, 3);
    bus.start = 1'b1;
    send_h(5003, 3);
    bus.start = 1'b0;
    check("t5_err", bus.err, 1);
    check("t5_busy", bus.busy, 1);
    send_hs(5000, 4, 16);
    send_ys(6000, 0, 8, 1'b0, 0);
    check("t5_busy_done", bus.busy, 0);
    bus.frm_ready = 1'b1;
    tick;
    bus.frm_ready = 1'b0;
    check("t5_frm_id4", bus.frm_id, 4);
    check("t5_D_h0", bus.H_r[0 +: N], 5000);
    check("t5_D_h3", bus.H_r[3*N +: N], 5003);
    check("t5_D_h15", bus.H_r[15*N +: N], 5015);
    check("t5_D_y7", bus.Y_r[7*N +: N], 6007);
    check("t5_err_sticky", bus.err, 1);
    // 5: asynchronous reset mid-frame
    start_pulse;
    send_hs(9900, 0, 7);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", bus.frm_valid, 0);
    check("t5_rst_err", bus.err, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_h_ready", bus.h_ready, 0);
    check("t5_rst_frm_id", bus.frm_id, 0);
    check("t5_rst_bus", bus.H_r == '0 && bus.Y_r == '0, 1);
    tick;
    rst = 1'b0;
    tick;
    start_pulse;
    send_hs(7000, 0, 16);
    send_ys(8000, 0, 8, 1'b0, 0);
    check("t5_E_valid", bus.frm_valid, 1);
    check("t5_E_id", bus.frm_id, 0);
    check("t5_E_h5", bus.H_r[5*N +: N], 7005);
    check("t5_E_y6", bus.Y_r[6*N +: N], 8006);
    check("t5_E_yi2", bus.Y_i[2*N +: N], yexp(2));
    // 6: consume E while F completes in the same cycle
    start_pulse;
    send_hs(9000, 0, 16);
    send_ys(9100, 0, 7, 1'b0, 0);
    bus.y_valid = 1'b1; bus.y_r = 9107; bus.y_i = 7;
    bus.frm_ready = 1'b1;
    check("t6_E_before", bus.H_r[0 +: N], 7000);
    check("t6_last_ready", bus.y_ready, 1);
    tick;
    bus.y_valid = 1'b0;
    bus.frm_ready = 1'b0;
    check("t6_valid", bus.frm_valid, 1);
    check("t6_frm_id", bus.frm_id, 1);
    check("t6_F_h0", bus.H_r[0 +: N], 9000);
    check("t6_F_y7", bus.Y_r[7*N +: N], 9107);
    tick;
    check("t6_valid_hold", bus.frm_valid, 1);
    check("t6_F_hold", bus.H_i[9*N +: N], 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
